gpr_file_sb: RTL and testbench

Parametrised successor to the core's general-purpose register file. It provides N_READ asynchronous read ports and two synchronous write ports: port 0 for the ALU result, port 1 for load writeback. The program counter is an internal register mapped at the top index, and a per-register busy scoreboard tracks outstanding loads. It sits between decode (read addresses and stall detection) and writeback (both write ports), and supplies the fetch PC.

---
 rtl/gpr_file_sb_pkg.sv | 17 +
 rtl/gpr_scoreboard.sv | 50 +++++
 rtl/gpr_file_sb.sv | 94 +++++++++
 tb/tb_gpr_file_sb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_file_sb_pkg.sv
// Shared constants for the general-purpose register file with scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default data and index widths
//   PC_ALIGN_MASK           : clears PC bits [1:0] on a direct PC write
//   pc_idx()                : index at which the PC is mapped (top index)
package gpr_file_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 4;

  // Wide enough for any practical DATA_W; truncated at the use site.
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

  function automatic int unsigned pc_idx(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard for outstanding loads.
//   sb_set/sb_addr : mark a register busy (load issued)
//   we1/wa1        : load writeback, clears busy
//   ra             : read addresses, one ADDR_W slice per read port
//   busy_vec       : registered busy state, PC bit always 0
//   rd_busy        : per read port, target busy and not cleared this cycle
module gpr_scoreboard
  import gpr_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned N_READ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [N_READ*ADDR_W-1:0] ra,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic [N_READ-1:0]        rd_busy
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned PC_IDX = pc_idx(ADDR_W);

  logic [DEPTH-1:0] busy_nxt;

  // Clear first, then set: a new load issued in the same cycle wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (sb_set && (sb_addr != ADDR_W'(PC_IDX))) busy_nxt[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

  // A same-cycle load writeback to the read target counts as ready.
  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < N_READ; i++) begin
      rd_busy[i] = busy_vec[ra[i*ADDR_W +: ADDR_W]] &&
                   !(we1 && (wa1 == ra[i*ADDR_W +: ADDR_W]));
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// General-purpose register file with internal PC and load scoreboard.
//   pc_en            : advance PC by PC_STEP
//   ra / rd          : N_READ combinational read ports (PC index reads pc+PC_READ_OFS)
//   rd_busy          : read port target has an outstanding load
//   we0/wa0/wd0      : ALU write port (wins on address collision)
//   we1/wa1/wd1      : load writeback port, also clears busy
//   sb_set/sb_addr   : mark a register busy
//   pc               : registered program counter
//   busy_vec         : scoreboard state
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned N_READ      = 2,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned PC_READ_OFS = 8,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_en,
  input  logic [N_READ*ADDR_W-1:0] ra,
  output logic [N_READ*DATA_W-1:0] rd,
  output logic [N_READ-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [DATA_W-1:0]        pc,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int unsigned PC_IDX  = pc_idx(ADDR_W);
  localparam logic [DATA_W-1:0] PC_MASK = DATA_W'(PC_ALIGN_MASK);
  localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [PC_IDX];

  // Storage writes; port 0 has priority on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PC_IDX; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < PC_IDX; i++) begin
        if (we0 && (wa0 == ADDR_W'(i)))      regs[i] <= wd0;
        else if (we1 && (wa1 == ADDR_W'(i))) regs[i] <= wd1;
      end
    end
  end

  // PC: direct write (word aligned) beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pc <= DATA_W'(RESET_PC);
    else if (we0 && (wa0 == PC_A)) pc <= wd0 & PC_MASK;
    else if (we1 && (wa1 == PC_A)) pc <= wd1 & PC_MASK;
    else if (pc_en)                pc <= pc + DATA_W'(PC_STEP);
  end

  // Reads: PC index, then write bypass (port 0 first), then storage.
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < N_READ; i++) begin
      if (ra[i*ADDR_W +: ADDR_W] == PC_A)
        rd[i*DATA_W +: DATA_W] = pc + DATA_W'(PC_READ_OFS);
      else if (we0 && (wa0 == ra[i*ADDR_W +: ADDR_W]))
        rd[i*DATA_W +: DATA_W] = wd0;
      else if (we1 && (wa1 == ra[i*ADDR_W +: ADDR_W]))
        rd[i*DATA_W +: DATA_W] = wd1;
      else
        rd[i*DATA_W +: DATA_W] = regs[ra[i*ADDR_W +: ADDR_W]];
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_READ (N_READ)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .we1      (we1),
    .wa1      (wa1),
    .ra       (ra),
    .busy_vec (busy_vec),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: default instance (ADDR_W=4, N_READ=2) plus a
// wider instance (ADDR_W=5, N_READ=3), checked against a register-array model.
module tb_gpr_file_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default instance
  logic        pc_en, we0, we1, sb_set;
  logic [7:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic [3:0]  wa0, wa1, sb_addr;
  logic [31:0] wd0, wd1, pc;
  logic [15:0] busy_vec;

  gpr_file_sb dut (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .sb_set(sb_set), .sb_addr(sb_addr), .pc(pc), .busy_vec(busy_vec)
  );

  // Wide instance
  logic        b_pc_en, b_we0, b_we1, b_sb_set;
  logic [14:0] b_ra;
  logic [95:0] b_rd;
  logic [2:0]  b_rd_busy;
  logic [4:0]  b_wa0, b_wa1, b_sb_addr;
  logic [31:0] b_wd0, b_wd1, b_pc;
  logic [31:0] b_busy_vec;

  gpr_file_sb #(.ADDR_W(5), .N_READ(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pc_en(b_pc_en), .ra(b_ra), .rd(b_rd), .rd_busy(b_rd_busy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr), .pc(b_pc), .busy_vec(b_busy_vec)
  );

  // Reference model of the default instance
  logic [31:0] m_reg [16];
  logic [31:0] m_pc;
  logic [15:0] m_busy;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pc = 32'd0;
    m_busy = '0;
  endtask

  // Apply one clock edge: port 1 then port 0, so port 0 ends up on top.
  task automatic model_edge();
    if (we1 && wa1 != 4'd15) m_reg[wa1] = wd1;
    if (we0 && wa0 != 4'd15) m_reg[wa0] = wd0;
    if (we0 && wa0 == 4'd15)      m_pc = wd0 & 32'hFFFF_FFFC;
    else if (we1 && wa1 == 4'd15) m_pc = wd1 & 32'hFFFF_FFFC;
    else if (pc_en)               m_pc = m_pc + 32'd4;
    if (we1) m_busy[wa1] = 1'b0;
    if (sb_set && sb_addr != 4'd15) m_busy[sb_addr] = 1'b1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15)          return m_pc + 32'd8;
    if (we0 && wa0 == a)     return wd0;
    if (we1 && wa1 == a)     return wd1;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    return m_busy[a] && !(we1 && wa1 == a);
  endfunction

  task automatic idle();
    pc_en = 0; we0 = 0; we1 = 0; sb_set = 0; ra = '0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; sb_addr = '0;
    b_pc_en = 0; b_we0 = 0; b_we1 = 0; b_sb_set = 0; b_ra = '0;
    b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0; b_sb_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    we0 = 1; wa0 = 4'd2; wd0 = 32'hFFFF_FFFF;
    we1 = 1; wa1 = 4'd15; wd1 = 32'h40;
    sb_set = 1; sb_addr = 4'd3; pc_en = 1;
    rst_n = 0;
    @(posedge clk); #1;
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    checks++; if (busy_vec !== 16'd0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy_vec, 16'd0); end
    @(negedge clk);
    idle();
    rst_n = 1;
    model_reset();
    for (int a = 0; a < 15; a++) begin
      ra[3:0] = 4'(a);
      ra[7:4] = 4'(14 - a);
      #1;
      checks++; if (rd[31:0] !== 32'd0) begin errors++; $display("FAIL reset_rd0[%0d]: got %h expected 0", a, rd[31:0]); end
      checks++; if (rd[63:32] !== 32'd0) begin errors++; $display("FAIL reset_rd1[%0d]: got %h expected 0", 14 - a, rd[63:32]); end
    end
  endtask

  task automatic test_write_read_bypass();
    idle();
    we0 = 1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF; ra[3:0] = 4'd3;
    #1;
    checks++; if (rd[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd: got %h expected %h", rd[31:0], 32'hDEAD_BEEF); end
    step();
    we0 = 0;
    #1;
    checks++; if (rd[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rd: got %h expected %h", rd[31:0], 32'hDEAD_BEEF); end
  endtask

  task automatic test_collision();
    idle();
    sb_set = 1; sb_addr = 4'd5;
    step();
    sb_set = 0; ra[3:0] = 4'd5;
    #1;
    checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL coll_busy_set: got %b expected 1", busy_vec[5]); end
    we0 = 1; wa0 = 4'd5; wd0 = 32'h11;
    we1 = 1; wa1 = 4'd5; wd1 = 32'h22;
    #1;
    checks++; if (rd[31:0] !== 32'h11) begin errors++; $display("FAIL coll_bypass: got %h expected %h", rd[31:0], 32'h11); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL coll_rd_busy: got %b expected 0", rd_busy[0]); end
    step();
    we0 = 0; we1 = 0;
    #1;
    checks++; if (rd[31:0] !== 32'h11) begin errors++; $display("FAIL coll_stored: got %h expected %h", rd[31:0], 32'h11); end
    checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL coll_busy_clr: got %b expected 0", busy_vec[5]); end
  endtask

  task automatic test_pc();
    idle();
    pc_en = 1;
    repeat (3) step();
    pc_en = 0; ra[3:0] = 4'd15;
    #1;
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL pc_inc: got %h expected %h", pc, 32'd12); end
    checks++; if (rd[31:0] !== 32'd20) begin errors++; $display("FAIL pc_read: got %h expected %h", rd[31:0], 32'd20); end
    we0 = 1; wa0 = 4'd15; wd0 = 32'h103; pc_en = 1;
    #1;
    checks++; if (rd[31:0] !== 32'd20) begin errors++; $display("FAIL pc_read_prio: got %h expected %h", rd[31:0], 32'd20); end
    step();
    we0 = 0; pc_en = 0;
    #1;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL pc_write: got %h expected %h", pc, 32'h100); end
    checks++; if (rd[31:0] !== 32'h108) begin errors++; $display("FAIL pc_write_read: got %h expected %h", rd[31:0], 32'h108); end
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set = 1; sb_addr = 4'd7;
    step();
    sb_set = 0; ra[7:4] = 4'd7;
    #1;
    checks++; if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL sb_set: got %b expected 1", busy_vec[7]); end
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_rd_busy: got %b expected 1", rd_busy[1]); end
    sb_set = 1; sb_addr = 4'd7; we1 = 1; wa1 = 4'd7; wd1 = 32'h77;
    #1;
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_setclr_rd_busy: got %b expected 0", rd_busy[1]); end
    step();
    sb_set = 0; we1 = 0;
    #1;
    checks++; if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b expected 1", busy_vec[7]); end
    we1 = 1; wa1 = 4'd7; wd1 = 32'h78;
    #1;
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_clr_rd_busy: got %b expected 0", rd_busy[1]); end
    step();
    we1 = 0;
    #1;
    checks++; if (busy_vec[7] !== 1'b0) begin errors++; $display("FAIL sb_clr: got %b expected 0", busy_vec[7]); end
    checks++; if (rd[63:32] !== 32'h78) begin errors++; $display("FAIL sb_load_data: got %h expected %h", rd[63:32], 32'h78); end
  endtask

  task automatic test_sweep();
    logic [31:0] exp3 [3];
    idle();
    b_we0 = 1; b_wa0 = 5'd1;  b_wd0 = 32'hA1;
    b_we1 = 1; b_wa1 = 5'd30; b_wd1 = 32'hB2;
    step();
    b_we1 = 0; b_wa0 = 5'd2; b_wd0 = 32'hC3;
    step();
    b_we0 = 0;
    b_ra = {5'd31, 5'd30, 5'd1};
    exp3 = '{32'hA1, 32'hB2, 32'h8};
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++; if (b_rd[p*32 +: 32] !== exp3[p]) begin errors++; $display("FAIL sweep_rd[%0d]: got %h expected %h", p, b_rd[p*32 +: 32], exp3[p]); end
    end
    b_ra[4:0] = 5'd2;
    #1;
    checks++; if (b_rd[31:0] !== 32'hC3) begin errors++; $display("FAIL sweep_rd_c3: got %h expected %h", b_rd[31:0], 32'hC3); end
    b_sb_set = 1; b_sb_addr = 5'd31;
    step();
    b_sb_set = 0;
    #1;
    checks++; if (b_busy_vec !== 32'd0) begin errors++; $display("FAIL sweep_pc_set_ignored: got %h expected 0", b_busy_vec); end
    checks++; if (b_rd_busy !== 3'd0) begin errors++; $display("FAIL sweep_rd_busy_idle: got %b expected 000", b_rd_busy); end
    b_sb_set = 1; b_sb_addr = 5'd30;
    step();
    b_sb_set = 0;
    #1;
    checks++; if (b_busy_vec !== 32'h4000_0000) begin errors++; $display("FAIL sweep_busy30: got %h expected %h", b_busy_vec, 32'h4000_0000); end
    checks++; if (b_rd_busy !== 3'b010) begin errors++; $display("FAIL sweep_rd_busy30: got %b expected 010", b_rd_busy); end
    checks++; if (b_pc !== 32'd0) begin errors++; $display("FAIL sweep_pc: got %h expected 0", b_pc); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    idle();
    for (int it = 0; it < 400; it++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 4'($urandom_range(0, 15)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 4'($urandom_range(0, 15)); wd1 = $urandom;
      sb_set = 1'($urandom_range(0, 1)); sb_addr = 4'($urandom_range(0, 15));
      pc_en = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      #1;
      for (int p = 0; p < 2; p++) begin
        e = exp_rd(ra[p*4 +: 4]);
        checks++; if (rd[p*32 +: 32] !== e) begin errors++; $display("FAIL rand_rd[%0d] it=%0d: got %h expected %h", p, it, rd[p*32 +: 32], e); end
        checks++; if (rd_busy[p] !== exp_busy(ra[p*4 +: 4])) begin errors++; $display("FAIL rand_rd_busy[%0d] it=%0d: got %b expected %b", p, it, rd_busy[p], exp_busy(ra[p*4 +: 4])); end
      end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc it=%0d: got %h expected %h", it, pc, m_pc); end
      checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rand_busy it=%0d: got %h expected %h", it, busy_vec, m_busy); end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_write_read_bypass();
    test_collision();
    test_pc();
    test_scoreboard();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
